// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
// Module   : spi_master
// Purpose  : Single-slave SPI controller, mode 0 (CPOL=0, CPHA=0), MSB first.
//            Accepts a transfer request (left-justified tx word + bit count)
//            on a valid/ready port, runs the SPI frame, and returns the
//            right-justified received word on a valid/ready response port.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clock      in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   req_valid  in   transfer request valid
//   req_ready  out  controller idle, request can be accepted
//   req_tx     in   data to send, first bit is req_tx[DATA_W-1]
//   req_len    in   number of bits to transfer (clamped to DATA_W)
//   rsp_valid  out  response valid
//   rsp_ready  in   response consumed
//   rsp_rx     out  received bits, right-justified, upper bits zero
//   sck        out  SPI clock, idles low
//   ss         out  slave select, active low
//   mosi       out  master out, idles high
//   miso       in   slave out
// ============================================================================
module spi_master #(
    parameter int DATA_W = 16,
    parameter int DIV    = 2,
    parameter int LEN_W  = $clog2(DATA_W + 1)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_tx,
    input  logic [LEN_W-1:0]  req_len,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rx,
    output logic              sck,
    output logic              ss,
    output logic              mosi,
    input  logic              miso
);

    // Divider counter must hold 0..DIV-1; keep at least one bit for DIV=1.
    localparam int              DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(DATA_W);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEAD  = 3'd1,
        S_SHIFT = 3'd2,
        S_TRAIL = 3'd3,
        S_GAP   = 3'd4,
        S_RESP  = 3'd5
    } state_t;

    state_t             state_q,     state_d;
    logic [DIV_W-1:0]   div_q,       div_d;
    logic [LEN_W-1:0]   bit_cnt_q,   bit_cnt_d;
    logic [LEN_W-1:0]   len_q,       len_d;
    logic [DATA_W-1:0]  tx_q,        tx_d;
    logic [DATA_W-1:0]  rx_q,        rx_d;
    logic [DATA_W-1:0]  rsp_rx_q,    rsp_rx_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               sck_q,       sck_d;
    logic               ss_q,        ss_d;
    logic               mosi_q,      mosi_d;

    logic               phase_end;

    // Last system cycle of the current sck half-period (or LEAD/TRAIL/GAP).
    assign phase_end = (div_q == DIV_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            bit_cnt_q   <= '0;
            len_q       <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            rsp_rx_q    <= '0;
            rsp_valid_q <= 1'b0;
            sck_q       <= 1'b0;
            ss_q        <= 1'b1;
            mosi_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_cnt_q   <= bit_cnt_d;
            len_q       <= len_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            rsp_rx_q    <= rsp_rx_d;
            rsp_valid_q <= rsp_valid_d;
            sck_q       <= sck_d;
            ss_q        <= ss_d;
            mosi_q      <= mosi_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bit_cnt_d   = bit_cnt_q;
        len_d       = len_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        rsp_rx_d    = rsp_rx_q;
        rsp_valid_d = rsp_valid_q;
        sck_d       = sck_q;
        ss_d        = ss_q;
        mosi_d      = mosi_q;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    div_d     = '0;
                    bit_cnt_d = '0;
                    rx_d      = '0;
                    if (req_len == '0) begin
                        // Empty transfer: answer at once, never touch the bus.
                        len_d       = '0;
                        rsp_rx_d    = '0;
                        rsp_valid_d = 1'b1;
                        state_d     = S_RESP;
                    end else begin
                        len_d   = (req_len > LEN_MAX) ? LEN_MAX : req_len;
                        // First bit goes out now; tx_q holds the remaining bits.
                        mosi_d  = req_tx[DATA_W-1];
                        tx_d    = req_tx << 1;
                        ss_d    = 1'b0;
                        state_d = S_LEAD;
                    end
                end
            end

            S_LEAD: begin
                if (phase_end) begin
                    div_d     = '0;
                    sck_d     = 1'b1;
                    rx_d      = {rx_q[DATA_W-2:0], miso};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    state_d   = S_SHIFT;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end

            S_SHIFT: begin
                if (phase_end) begin
                    div_d = '0;
                    if (sck_q) begin
                        // Falling edge: either present the next bit or end the frame.
                        sck_d = 1'b0;
                        if (bit_cnt_q == len_q) begin
                            mosi_d  = 1'b1;
                            state_d = S_TRAIL;
                        end else begin
                            mosi_d = tx_q[DATA_W-1];
                            tx_d   = tx_q << 1;
                        end
                    end else begin
                        // Rising edge: sample the slave.
                        sck_d     = 1'b1;
                        rx_d      = {rx_q[DATA_W-2:0], miso};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end

            S_TRAIL: begin
                if (phase_end) begin
                    div_d   = '0;
                    ss_d    = 1'b1;
                    state_d = S_GAP;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end

            S_GAP: begin
                if (phase_end) begin
                    div_d       = '0;
                    rsp_rx_d    = rx_q;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end

            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rx    = rsp_rx_q;
    assign sck       = sck_q;
    assign ss        = ss_q;
    assign mosi      = mosi_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_master
// Purpose  : Directed self-checking bench for spi_master. Instance u_dut
//            (DIV=2) runs loopback / fixed-miso / backpressure / reset
//            scenarios; instance u_dut_rev (DIV=1) talks to a behavioural
//            bit-reversal slave.
// Revision : 1.0  initial release
// ============================================================================
module tb_spi_master;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    always #5 clock = ~clock;

    int vec  = 0;
    int errs = 0;

    // ---------------- instance 0 (DIV=2) ----------------
    logic        req_valid0 = 1'b0;
    logic        req_ready0;
    logic [15:0] req_tx0    = 16'h0000;
    logic [4:0]  req_len0   = 5'd0;
    logic        rsp_valid0;
    logic        rsp_ready0 = 1'b0;
    logic [15:0] rsp_rx0;
    logic        sck0, ss0, mosi0, miso0;
    logic [1:0]  miso_mode  = 2'd2;   // 0: tie low, 1: tie high, 2: loopback

    assign miso0 = (miso_mode == 2'd2) ? mosi0 : miso_mode[0];

    spi_master #(.DATA_W(16), .DIV(2)) u_dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_valid (req_valid0),
        .req_ready (req_ready0),
        .req_tx    (req_tx0),
        .req_len   (req_len0),
        .rsp_valid (rsp_valid0),
        .rsp_ready (rsp_ready0),
        .rsp_rx    (rsp_rx0),
        .sck       (sck0),
        .ss        (ss0),
        .mosi      (mosi0),
        .miso      (miso0)
    );

    int          rise_lo0 = 0;   // sck rises while ss low
    int          rise_hi0 = 0;   // sck rises while ss high (must never happen)
    int          ss_fall0 = 0;
    logic [63:0] mosi_log0 = '0;

    always @(posedge sck0) begin
        if (!ss0) begin
            rise_lo0  = rise_lo0 + 1;
            mosi_log0 = {mosi_log0[62:0], mosi0};
        end else begin
            rise_hi0 = rise_hi0 + 1;
        end
    end

    always @(negedge ss0) ss_fall0 = ss_fall0 + 1;

    // ---------------- instance 1 (DIV=1) + bit-reversal slave ----------------
    logic        req_valid1 = 1'b0;
    logic        req_ready1;
    logic [15:0] req_tx1    = 16'h0000;
    logic [4:0]  req_len1   = 5'd0;
    logic        rsp_valid1;
    logic        rsp_ready1 = 1'b0;
    logic [15:0] rsp_rx1;
    logic        sck1, ss1, mosi1;
    logic        miso1 = 1'b1;

    spi_master #(.DATA_W(16), .DIV(1)) u_dut_rev (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_valid (req_valid1),
        .req_ready (req_ready1),
        .req_tx    (req_tx1),
        .req_len   (req_len1),
        .rsp_valid (rsp_valid1),
        .rsp_ready (rsp_ready1),
        .rsp_rx    (rsp_rx1),
        .sck       (sck1),
        .ss        (ss1),
        .mosi      (mosi1),
        .miso      (miso1)
    );

    logic [7:0]  sl_rx     = '0;
    logic [4:0]  sl_cnt    = '0;
    logic [63:0] mosi_log1 = '0;

    // Slave receives 8 bits, then returns them LSB first (bit-reversed),
    // changing miso on sck falls; idles at 1.
    always @(posedge sck1) begin
        if (!ss1) begin
            if (sl_cnt < 5'd8) sl_rx = {sl_rx[6:0], mosi1};
            sl_cnt    = sl_cnt + 5'd1;
            mosi_log1 = {mosi_log1[62:0], mosi1};
        end
    end

    always @(negedge sck1) begin
        if (!ss1 && sl_cnt >= 5'd8 && sl_cnt < 5'd16) miso1 = sl_rx[sl_cnt[2:0]];
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Full transfer on instance 0 including response handshake.
    task automatic run_xfer0(input logic [15:0] tx, input logic [4:0] len,
                             output logic [15:0] rx, output int cyc,
                             output int rises, output int hrises);
        int r0;
        int h0;
        r0 = rise_lo0;
        h0 = rise_hi0;
        req_valid0 = 1'b1;
        req_tx0    = tx;
        req_len0   = len;
        tick();
        req_valid0 = 1'b0;
        req_tx0    = 16'hFFFF;   // changing inputs must not disturb the transfer
        req_len0   = 5'd3;
        cyc = 0;
        while (!rsp_valid0 && cyc < 500) begin
            tick();
            cyc++;
        end
        if (!rsp_valid0) begin
            vec++; errs++;
            $display("FAIL xfer_timeout: rsp_valid=%b after %0d cycles, required 1", rsp_valid0, cyc);
        end
        rx     = rsp_rx0;
        rises  = rise_lo0 - r0;
        hrises = rise_hi0 - h0;
        rsp_ready0 = 1'b1;
        tick();
        rsp_ready0 = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        tick(); tick();
        vec++;
        if ({sck0, ss0, mosi0, req_ready0, rsp_valid0} !== 5'b01110) begin
            errs++;
            $display("FAIL reset_ctrl: {sck,ss,mosi,req_ready,rsp_valid}=%b, required 01110",
                     {sck0, ss0, mosi0, req_ready0, rsp_valid0});
        end
        vec++;
        if (rsp_rx0 !== 16'h0000) begin
            errs++;
            $display("FAIL reset_rx: rsp_rx=%h, required 0000", rsp_rx0);
        end
        reset_n = 1'b1;
        tick();
        vec++;
        if (req_ready0 !== 1'b1) begin
            errs++;
            $display("FAIL reset_ready: req_ready=%b, required 1", req_ready0);
        end
    endtask

    task automatic test_loopback();
        logic [15:0] rx;
        int cyc, rises, hr;
        miso_mode = 2'd2;
        run_xfer0(16'hA5C3, 5'd16, rx, cyc, rises, hr);
        vec++;
        if (rx !== 16'hA5C3) begin
            errs++; $display("FAIL loop_rx: rsp_rx=%h, required a5c3", rx);
        end
        vec++;
        if (cyc != 68) begin
            errs++; $display("FAIL loop_latency: %0d cycles, required 68", cyc);
        end
        vec++;
        if (rises != 16 || hr != 0) begin
            errs++; $display("FAIL loop_rises: ss-low %0d ss-high %0d, required 16 0", rises, hr);
        end
        vec++;
        if (mosi_log0[15:0] !== 16'hA5C3) begin
            errs++; $display("FAIL loop_mosi: mosi bits %h, required a5c3", mosi_log0[15:0]);
        end
        vec++;
        if (req_ready0 !== 1'b1 || rsp_valid0 !== 1'b0) begin
            errs++; $display("FAIL loop_idle: req_ready=%b rsp_valid=%b, required 1 0", req_ready0, rsp_valid0);
        end
    endtask

    task automatic test_miso_levels();
        logic [15:0] rx;
        int cyc, rises, hr;
        miso_mode = 2'd1;
        run_xfer0(16'h0000, 5'd5, rx, cyc, rises, hr);
        vec++;
        if (rx !== 16'h001F) begin
            errs++; $display("FAIL miso1_rx: rsp_rx=%h, required 001f", rx);
        end
        vec++;
        if (mosi_log0[4:0] !== 5'b00000 || rises != 5) begin
            errs++; $display("FAIL miso1_mosi: mosi bits %b rises %0d, required 00000 5", mosi_log0[4:0], rises);
        end
        miso_mode = 2'd0;
        run_xfer0(16'hFFFF, 5'd5, rx, cyc, rises, hr);
        vec++;
        if (rx !== 16'h0000) begin
            errs++; $display("FAIL miso0_rx: rsp_rx=%h, required 0000", rx);
        end
        miso_mode = 2'd2;
    endtask

    task automatic test_len_clamp();
        logic [15:0] rx;
        int cyc, rises, hr;
        run_xfer0(16'h1234, 5'd20, rx, cyc, rises, hr);
        vec++;
        if (rx !== 16'h1234 || rises != 16 || cyc != 68) begin
            errs++; $display("FAIL clamp: rx=%h rises=%0d cyc=%0d, required 1234 16 68", rx, rises, cyc);
        end
    endtask

    task automatic test_len_zero();
        logic [15:0] rx;
        int cyc, rises, hr, f0;
        f0 = ss_fall0;
        run_xfer0(16'hFFFF, 5'd0, rx, cyc, rises, hr);
        vec++;
        // Visible in the cycle right after the accept edge.
        if (cyc != 0 || rx !== 16'h0000) begin
            errs++; $display("FAIL len0_rsp: cyc=%0d rx=%h, required 0 0000", cyc, rx);
        end
        vec++;
        if (ss_fall0 != f0 || rises != 0 || hr != 0) begin
            errs++; $display("FAIL len0_bus: ss falls %0d sck rises %0d/%0d, required 0 0/0",
                             ss_fall0 - f0, rises, hr);
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        req_valid0 = 1'b1; req_tx0 = 16'h9000; req_len0 = 5'd4;
        tick();
        req_valid0 = 1'b0;
        cyc = 0;
        while (!rsp_valid0 && cyc < 200) begin tick(); cyc++; end
        vec++;
        if (rsp_valid0 !== 1'b1 || cyc != 20 || rsp_rx0 !== 16'h0009) begin
            errs++; $display("FAIL bp_first: valid=%b cyc=%0d rx=%h, required 1 20 0009", rsp_valid0, cyc, rsp_rx0);
        end
        // Second request waits while the response is held.
        req_valid0 = 1'b1; req_tx0 = 16'h6000; req_len0 = 5'd4;
        for (int i = 0; i < 10; i++) begin
            tick();
            vec++;
            if ({rsp_valid0, req_ready0, ss0, rsp_rx0} !== {3'b101, 16'h0009}) begin
                errs++; $display("FAIL bp_hold[%0d]: valid/ready/ss=%b rx=%h, required 101 0009",
                                 i, {rsp_valid0, req_ready0, ss0}, rsp_rx0);
            end
        end
        rsp_ready0 = 1'b1;
        tick();
        rsp_ready0 = 1'b0;
        vec++;
        if ({rsp_valid0, req_ready0} !== 2'b01 || rsp_rx0 !== 16'h0009) begin
            errs++; $display("FAIL bp_release: valid/ready=%b rx=%h, required 01 0009", {rsp_valid0, req_ready0}, rsp_rx0);
        end
        tick();
        req_valid0 = 1'b0;
        vec++;
        if ({req_ready0, ss0} !== 2'b00) begin
            errs++; $display("FAIL bp_second_accept: ready/ss=%b, required 00", {req_ready0, ss0});
        end
        cyc = 0;
        while (!rsp_valid0 && cyc < 200) begin tick(); cyc++; end
        vec++;
        if (rsp_valid0 !== 1'b1 || rsp_rx0 !== 16'h0006) begin
            errs++; $display("FAIL bp_second_rx: valid=%b rx=%h, required 1 0006", rsp_valid0, rsp_rx0);
        end
        rsp_ready0 = 1'b1;
        tick();
        rsp_ready0 = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [15:0] rx;
        int cyc, rises, hr, r0;
        r0 = rise_lo0;
        req_valid0 = 1'b1; req_tx0 = 16'hFF00; req_len0 = 5'd8;
        tick();
        req_valid0 = 1'b0;
        cyc = 0;
        while ((rise_lo0 - r0) < 3 && cyc < 100) begin tick(); cyc++; end
        vec++;
        if ((rise_lo0 - r0) != 3) begin
            errs++; $display("FAIL rst_mid_reach: rises=%0d, required 3", rise_lo0 - r0);
        end
        reset_n = 1'b0;
        #1;
        vec++;
        if ({ss0, sck0, mosi0, rsp_valid0} !== 4'b1010) begin
            errs++; $display("FAIL rst_mid_async: {ss,sck,mosi,rsp_valid}=%b, required 1010",
                             {ss0, sck0, mosi0, rsp_valid0});
        end
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 30; i++) tick();
        vec++;
        if (req_ready0 !== 1'b1 || rsp_valid0 !== 1'b0) begin
            errs++; $display("FAIL rst_mid_idle: req_ready=%b rsp_valid=%b, required 1 0", req_ready0, rsp_valid0);
        end
        run_xfer0(16'h5A00, 5'd8, rx, cyc, rises, hr);
        vec++;
        if (rx !== 16'h005A || cyc != 36) begin
            errs++; $display("FAIL rst_mid_fresh: rx=%h cyc=%0d, required 005a 36", rx, cyc);
        end
    endtask

    task automatic test_bitrev();
        int cyc;
        sl_cnt = '0;
        miso1  = 1'b1;
        req_valid1 = 1'b1; req_tx1 = 16'hB100; req_len1 = 5'd16;
        tick();
        req_valid1 = 1'b0;
        req_tx1    = 16'h0000;
        cyc = 0;
        while (!rsp_valid1 && cyc < 200) begin tick(); cyc++; end
        vec++;
        if (rsp_valid1 !== 1'b1 || cyc != 34) begin
            errs++; $display("FAIL rev_latency: valid=%b cyc=%0d, required 1 34", rsp_valid1, cyc);
        end
        vec++;
        if (mosi_log1[15:8] !== 8'b10110001) begin
            errs++; $display("FAIL rev_mosi: first bits %b, required 10110001", mosi_log1[15:8]);
        end
        vec++;
        if (rsp_rx1 !== 16'hFF8D) begin
            errs++; $display("FAIL rev_rx: rsp_rx=%h, required ff8d", rsp_rx1);
        end
        rsp_ready1 = 1'b1;
        tick();
        rsp_ready1 = 1'b0;
        vec++;
        if (req_ready1 !== 1'b1 || ss1 !== 1'b1 || sck1 !== 1'b0) begin
            errs++; $display("FAIL rev_idle: ready/ss/sck=%b, required 110", {req_ready1, ss1, sck1});
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_miso_levels();
        test_len_clamp();
        test_len_zero();
        test_backpressure();
        test_reset_mid();
        test_bitrev();
        vec++;
        if (rise_hi0 != 0) begin
            errs++; $display("FAIL sck_while_ss_high: %0d rises, required 0", rise_hi0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/spi_master.md
Name: spi_master

Overview:
- Single-slave SPI controller, mode 0 (CPOL=0, CPHA=0), MSB first.
- Opposite end of the SPI slave peripherals in perip/: drives sck/ss/mosi and samples miso.
- Receives a transfer request (tx word + bit count) over a valid/ready port and returns the received word over a valid/ready response port.
- Used by the bench and SoC glue to exercise SPI slaves such as the bit-reversal peripheral (8 bits out, then 8 bits back).

Parameters:
- DATA_W, 16, maximum bits per transfer; width of the tx/rx words.
- DIV, 2, system clocks per sck half-period; legal range ≥1.
- LEN_W, $clog2(DATA_W+1), width of req_len.

Ports:
- clock  in  1  system clock; all logic is on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  transfer request valid.
- req_ready  out  1  controller can accept a request.
- req_tx  in  DATA_W  data to send. The first bit sent is req_tx[DATA_W-1] (left-justified).
- req_len  in  LEN_W  number of bits to transfer.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed.
- rsp_rx  out  DATA_W  received bits, right-justified; bits above len are 0.
- sck  out  1  SPI clock; idles at 0.
- ss  out  1  slave select, active low.
- mosi  out  1  master out; idles at 1.
- miso  in  1  slave out.

Behaviour:
- Reset (async assert): state=IDLE, sck=0, ss=1, mosi=1, req_ready=1, rsp_valid=0, rsp_rx=0, all counters=0.
- Reset mid-transfer aborts immediately with the same values; no response is produced.
- States: IDLE, LEAD, SHIFT, TRAIL, GAP, RESP.
- req_ready=1 only in IDLE. A request is accepted on a clock edge E0 where req_valid && req_ready.
- On accept:
  - Latch tx, and len clamped to DATA_W.
  - Clear the rx shift register.
  - mosi ← first bit; ss ← 0; enter LEAD.
- Length 0: go directly to RESP with rsp_rx=0; ss never asserts.
- A divider counter runs DIV cycles per phase.
- Edge timing relative to E0:
  - sck rises at E0+DIV (LEAD→SHIFT).
  - sck falls at E0+2·DIV, rises at E0+3·DIV, and so on.
  - The k-th rise (k=1..len) is at E0+(2k−1)·DIV.
- Each sck rise samples miso into the rx LSB (rx ← {rx[DATA_W-2:0], miso}) and increments bit_cnt.
- Each sck fall with bits remaining drives the next tx bit on mosi, so mosi is stable for a full half-period before the next rise.
- After the len-th bit, the following fall at E0+2·len·DIV leaves sck=0, mosi=1, and enters TRAIL.
- TRAIL: ss stays 0 for DIV cycles; ss ← 1 at E0+(2·len+1)·DIV; enter GAP.
- GAP: ss stays high for DIV cycles.
- Response: at E0+(2·len+2)·DIV, rsp_rx ← rx and rsp_valid ← 1 (RESP).
- RESP: hold rsp_valid and rsp_rx until rsp_valid && rsp_ready, then go to IDLE next cycle (rsp_valid=0).
- rsp_rx keeps its value after the handshake until the next response.
- Simultaneous events: req_valid is ignored outside IDLE. rsp_ready outside RESP has no effect.
- req_tx/req_len may change after acceptance without affecting the transfer in progress.
- sck never glitches: its only transitions are those listed above, and it stays 0 whenever ss=1.
- Back-to-back requests: minimum ss-high time between transfers is DIV+2 cycles (GAP + RESP + IDLE).

Test Plan:
- Loopback (miso tied to mosi), DIV=2, len=16, tx=0xA5C3 → rsp_rx=0xA5C3. rsp_valid first high 68 cycles after accept; exactly 16 sck rising edges while ss=0.
- miso held at 1, len=5, tx=0x0000 → rsp_rx=0x001F, and mosi=0 on all 5 sampled edges. miso held at 0, len=5 → rsp_rx=0x0000.
- Bit-reversal slave attached, DIV=1, len=16, tx=0xB100 → first 8 mosi bits 1,0,1,1,0,0,0,1. rsp_rx upper byte = 0xFF (slave idles at 1); lower byte matches the slave's returned bits.
- len=0 with req_valid → ss stays 1, no sck edges; rsp_valid high the cycle after accept with rsp_rx=0.
- Response backpressure: rsp_ready=0 for 10 cycles → rsp_valid and rsp_rx stable, req_ready=0, a second req_valid is not accepted. Raise rsp_ready → IDLE next cycle, then the second request is accepted.
- reset_n pulsed low mid-SHIFT (after 3 rises, len=8) → same cycle: ss=1, sck=0, mosi=1, rsp_valid=0. After release req_ready=1, and a fresh loopback transfer of 0x5A00, len=8, returns rsp_rx=0x005A.
